// File: rtl/xor_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module   : xor_parity_rx
//  Purpose  : Serial frame receiver with XOR parity checking. Deserialises
//             start / DATA_W data (LSB first) / parity / stop frames sampled
//             on a bit-rate strobe. Each completed word is presented, with its
//             parity and framing status, in a single valid/ready holding
//             register.
//  Params   : DATA_W - data bits per frame (2..32)
//             ODD    - parity sense, 0 = even, 1 = odd
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-high reset
//             bit_en     - one-cycle strobe per bit period
//             rx_bit     - serial line (idles high), sampled when bit_en=1
//             rx_data    - received word
//             rx_valid   - holding register occupied
//             rx_ready   - consumer accepts the word when rx_valid&&rx_ready
//             parity_err - parity mismatch for the held word
//             frame_err  - stop bit sampled low for the held word
//             overrun    - sticky: a completed frame was dropped (holding full)
//             busy       - receiver is inside a frame
//             err_cnt    - saturating count of loaded frames with any error
//                          (present only with XOR_PARITY_RX_ERRCNT_EN)
//  Options  : `define XOR_PARITY_RX_ERRCNT_EN adds the err_cnt port/counter.
//  Revision : 1.0 - initial release
// ============================================================================
module xor_parity_rx #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
`ifdef XOR_PARITY_RX_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              busy
);

    localparam int               CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_W - 1);
    localparam logic             c_odd  = (ODD != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_acc;
    logic               r_perr;

    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_done;
    logic               w_free;
    logic               w_ferr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: moves only on bit strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bit_en) begin
            case (r_state)
                ST_IDLE:   if (!rx_bit) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_cnt == c_last) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Deserialiser datapath: counter, shift register, parity accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_acc   <= 1'b0;
            r_perr  <= 1'b0;
        end else if (bit_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        r_cnt <= '0;
                        // Seeding with the parity sense makes acc^parity_bit
                        // equal to 1 exactly when the frame is in error.
                        r_acc <= c_odd;
                    end
                end
                ST_DATA: begin
                    // Right shift: the first (LSB) bit ends up in bit 0.
                    r_shift <= {rx_bit, r_shift[DATA_W-1:1]};
                    r_acc   <= r_acc ^ rx_bit;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                ST_PARITY: begin
                    r_perr <= r_acc ^ rx_bit;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    assign w_done = bit_en && (r_state == ST_STOP);
    assign w_ferr = ~rx_bit;
    // A slot being drained this cycle can accept the new frame directly.
    assign w_free = !r_valid || rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_done && w_free) begin
            r_data       <= r_shift;
            r_valid      <= 1'b1;
            r_parity_err <= r_perr;
            r_frame_err  <= w_ferr;
        end else if (w_done) begin
            r_overrun    <= 1'b1;
        end else if (r_valid && rx_ready) begin
            r_valid      <= 1'b0;
        end
    end

`ifdef XOR_PARITY_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_done && w_free && (r_perr || w_ferr) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_xor_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_parity_rx
//  Purpose  : Self-checking bench for xor_parity_rx. Two instances (even and
//             odd parity) share one serial stimulus; a frame-level model
//             predicts the holding register contents and flags.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xor_parity_rx;

    localparam int DW  = 8;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0;
    logic rx_bit = 1'b1;
    logic rx_ready = 1'b0;

    logic [DW-1:0] d0_data, d1_data;
    logic d0_valid, d0_perr, d0_ferr, d0_ovr, d0_busy;
    logic d1_valid, d1_perr, d1_ferr, d1_ovr, d1_busy;
`ifdef XOR_PARITY_RX_ERRCNT_EN
    logic [7:0] d0_ecnt, d1_ecnt;
`endif

    always #5 clk = ~clk;

    xor_parity_rx #(.DATA_W(DW), .ODD(0)) u_even (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx_bit(rx_bit),
        .rx_data(d0_data), .rx_valid(d0_valid), .rx_ready(rx_ready),
        .parity_err(d0_perr), .frame_err(d0_ferr), .overrun(d0_ovr),
`ifdef XOR_PARITY_RX_ERRCNT_EN
        .err_cnt(d0_ecnt),
`endif
        .busy(d0_busy)
    );

    xor_parity_rx #(.DATA_W(DW), .ODD(1)) u_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx_bit(rx_bit),
        .rx_data(d1_data), .rx_valid(d1_valid), .rx_ready(rx_ready),
        .parity_err(d1_perr), .frame_err(d1_ferr), .overrun(d1_ovr),
`ifdef XOR_PARITY_RX_ERRCNT_EN
        .err_cnt(d1_ecnt),
`endif
        .busy(d1_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model. The driver announces the frame it is sending
    // (start/stop strobe markers plus the expected word and status);
    // the model applies the holding-register rules at each clock edge.
    // ------------------------------------------------------------------
    logic          f_start = 1'b0;
    logic          f_stop  = 1'b0;
    logic [DW-1:0] p_data  = '0;
    logic          p_perr0 = 1'b0;
    logic          p_perr1 = 1'b0;
    logic          p_ferr  = 1'b0;

    logic [DW-1:0] m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_perr0 = 1'b0;
    logic          m_perr1 = 1'b0;
    logic          m_ferr  = 1'b0;
    logic          m_ovr   = 1'b0;
    logic          m_busy  = 1'b0;
    int            m_ecnt0 = 0;
    int            m_ecnt1 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_perr0 <= 1'b0;
            m_perr1 <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            m_busy  <= 1'b0;
            m_ecnt0 <= 0;
            m_ecnt1 <= 0;
        end else begin
            if (bit_en && f_start) m_busy <= 1'b1;
            if (bit_en && f_stop) begin
                m_busy <= 1'b0;
                if (!m_valid || rx_ready) begin
                    m_valid <= 1'b1;
                    m_data  <= p_data;
                    m_perr0 <= p_perr0;
                    m_perr1 <= p_perr1;
                    m_ferr  <= p_ferr;
                    if ((p_perr0 || p_ferr) && m_ecnt0 < 255) m_ecnt0 <= m_ecnt0 + 1;
                    if ((p_perr1 || p_ferr) && m_ecnt1 < 255) m_ecnt1 <= m_ecnt1 + 1;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && rx_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_even", d0_valid, m_valid);
            chk("valid_odd",  d1_valid, m_valid);
            chk("busy_even",  d0_busy,  m_busy);
            chk("busy_odd",   d1_busy,  m_busy);
            chk("ovr_even",   d0_ovr,   m_ovr);
            chk("ovr_odd",    d1_ovr,   m_ovr);
            if (m_valid) begin
                chk("data_even", d0_data, m_data);
                chk("data_odd",  d1_data, m_data);
                chk("perr_even", d0_perr, m_perr0);
                chk("perr_odd",  d1_perr, m_perr1);
                chk("ferr_even", d0_ferr, m_ferr);
                chk("ferr_odd",  d1_ferr, m_ferr);
            end
`ifdef XOR_PARITY_RX_ERRCNT_EN
            chk("ecnt_even", d0_ecnt, m_ecnt0);
            chk("ecnt_odd",  d1_ecnt, m_ecnt1);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit period: a strobe cycle followed (except for stop) by idle gap.
    task automatic strobe(input logic b, input logic is_start, input logic is_stop);
        rx_bit  = b;
        bit_en  = 1'b1;
        f_start = is_start;
        f_stop  = is_stop;
        cycles(1);
        bit_en  = 1'b0;
        f_start = 1'b0;
        f_stop  = 1'b0;
        rx_bit  = 1'b1;
        if (!is_stop) cycles(GAP);
    endtask

    // Returns just after the edge that sampled the stop bit.
    task automatic send_frame(input logic [DW-1:0] d, input logic pbit,
                              input logic sbit, input logic rdy_on_stop);
        int ones;
        ones    = $countones(d) + int'(pbit);
        p_data  = d;
        p_perr0 = (ones % 2) != 0;   // even sense: total ones must be even
        p_perr1 = (ones % 2) != 1;   // odd sense: total ones must be odd
        p_ferr  = !sbit;
        strobe(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DW; i++) strobe(d[i], 1'b0, 1'b0);
        strobe(pbit, 1'b0, 1'b0);
        if (rdy_on_stop) rx_ready = 1'b1;
        strobe(sbit, 1'b0, 1'b1);
        if (rdy_on_stop) rx_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        cycles(3);
        chk("rst_valid", d0_valid, 1'b0);
        chk("rst_busy",  d0_busy,  1'b0);
        chk("rst_data",  d0_data,  8'h00);
        chk("rst_ovr",   d0_ovr,   1'b0);
        rst = 1'b0;
        rx_ready = 1'b1;
        cycles(2);

        // Clean 0xA5, even parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("t1_valid", d0_valid, 1'b1);
        chk("t1_data",  d0_data,  8'hA5);
        chk("t1_perr",  d0_perr,  1'b0);
        chk("t1_ferr",  d0_ferr,  1'b0);
        cycles(1);
        chk("t1_valid_one_cycle", d0_valid, 1'b0);
        cycles(2);

        // Wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("t2_data", d0_data, 8'hA5);
        chk("t2_perr", d0_perr, 1'b1);
        chk("t2_ferr", d0_ferr, 1'b0);
`ifdef XOR_PARITY_RX_ERRCNT_EN
        chk("t2_ecnt", d0_ecnt, 8'd1);
`endif
        cycles(2);

        // Framing error, then a clean frame
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        chk("t3_ferr", d0_ferr, 1'b1);
        chk("t3_perr", d0_perr, 1'b0);
        chk("t3_busy", d0_busy, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        chk("t3b_data", d0_data, 8'h11);
        chk("t3b_ferr", d0_ferr, 1'b0);
        chk("t3b_perr", d0_perr, 1'b0);
        cycles(2);

        // Overrun
        rx_ready = 1'b0;
        cycles(1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        chk("t4_data_first", d0_data, 8'h3C);
        cycles(2);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        chk("t4_data_held", d0_data,  8'h3C);
        chk("t4_ovr",       d0_ovr,   1'b1);
        chk("t4_valid",     d0_valid, 1'b1);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        chk("t4_drained", d0_valid, 1'b0);
        chk("t4_ovr_sticky", d0_ovr, 1'b1);
        cycles(2);

        // Asynchronous reset after the 4th data bit
        strobe(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'(8'h5A >> i), 1'b0, 1'b0);
        chk("t5_busy_mid", d0_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy",  d0_busy,  1'b0);
        chk("t5_rst_ovr",   d0_ovr,   1'b0);
        chk("t5_rst_valid", d0_valid, 1'b0);
        chk("t5_rst_data",  d1_data,  8'h00);
        cycles(1);
        rst = 1'b0;
        rx_ready = 1'b1;
        cycles(1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("t5_data", d0_data, 8'h5A);
        chk("t5_perr", d0_perr, 1'b0);
        chk("t5_ferr", d0_ferr, 1'b0);
        cycles(2);

        // New frame loads on the same edge the held word is drained
        rx_ready = 1'b0;
        cycles(1);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        cycles(2);
        send_frame(8'h34, 1'b1, 1'b1, 1'b1);
        chk("t7_valid", d0_valid, 1'b1);
        chk("t7_data",  d0_data,  8'h34);
        chk("t7_ovr",   d0_ovr,   1'b0);
        rx_ready = 1'b1;
        cycles(2);

        // Odd parity instance
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        chk("t6_odd_ok",    d1_perr, 1'b0);
        chk("t6_even_bad",  d0_perr, 1'b1);
        cycles(2);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        chk("t6_odd_bad",   d1_perr, 1'b1);
        chk("t6_even_ok",   d0_perr, 1'b0);
        cycles(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
